// File: rtl/avli2c_write_buffer_if.sv
// Bus between the Avalon-side register file and the I2C write staging buffer.
// The master modport is the register file / I2C engine side; slave is the buffer.
interface avli2c_write_buffer_if #(
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned DATA_BYTES = 4
);
    localparam int unsigned PEND_W = $clog2(ADDR_BYTES + DATA_BYTES + 1);

    logic [8*ADDR_BYTES-1:0] address_i;
    logic                    address_valid_i;
    logic [8*DATA_BYTES-1:0] data_i;
    logic [DATA_BYTES-1:0]   data_valid_i;
    logic                    clear_i;
    logic                    busy_o;
    logic                    i2c_data_available_o;
    logic [7:0]              i2c_data_o;
    logic                    i2c_last_o;
    logic                    i2c_read_data_i;
    logic [PEND_W-1:0]       pending_o;
    logic                    overflow_o;

    modport master (
        output address_i, address_valid_i, data_i, data_valid_i, clear_i, i2c_read_data_i,
        input  busy_o, i2c_data_available_o, i2c_data_o, i2c_last_o, pending_o, overflow_o
    );

    modport slave (
        input  address_i, address_valid_i, data_i, data_valid_i, clear_i, i2c_read_data_i,
        output busy_o, i2c_data_available_o, i2c_data_o, i2c_last_o, pending_o, overflow_o
    );
endinterface

// File: rtl/avli2c_write_buffer.sv
// Address/data staging buffer: collects a word address plus byte-enabled data lanes and
// drains them to the I2C master as a show-ahead byte stream (address MSB first, then lanes).
module avli2c_write_buffer #(
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned DATA_BYTES = 4,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input logic                    clock_i,
    input logic                    reset_i,
    avli2c_write_buffer_if.slave   bus
);
    localparam int unsigned PW  = $clog2(ADDR_BYTES + DATA_BYTES + 1);
    localparam int unsigned AIW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int unsigned LW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                  r_state,      w_state_nxt;
    logic [8*ADDR_BYTES-1:0] r_address,    w_address_nxt;
    logic                    r_addr_valid, w_addr_valid_nxt;
    logic [AIW-1:0]          r_addr_idx,   w_addr_idx_nxt;
    logic [8*DATA_BYTES-1:0] r_data,       w_data_nxt;
    logic [DATA_BYTES-1:0]   r_lane_valid, w_lane_valid_nxt;
    logic                    r_overflow,   w_overflow_nxt;

    logic [LW-1:0] w_head_lane;
    logic [PW-1:0] w_lane_cnt;
    logic [PW-1:0] w_pending;
    logic          w_avail;
    logic [7:0]    w_head_byte;
    logic          w_last_addr;
    logic          w_pop;
    logic          w_wr_req;
    logic          w_wr_ok;

    // Later matches overwrite earlier ones, so scan in reverse of the send order.
    always_comb begin
        w_head_lane = '0;
        w_lane_cnt  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_lane_valid[MSB_FIRST ? i : DATA_BYTES-1-i]) begin
                w_head_lane = LW'(MSB_FIRST ? i : DATA_BYTES-1-i);
            end
            w_lane_cnt = w_lane_cnt + PW'(r_lane_valid[i]);
        end
    end

    always_comb begin
        w_pending   = (r_addr_valid ? (PW'(ADDR_BYTES) - PW'(r_addr_idx)) : '0) + w_lane_cnt;
        w_avail     = (w_pending != '0);
        w_last_addr = (r_addr_idx == AIW'(ADDR_BYTES - 1));
        if (r_addr_valid) begin
            w_head_byte = r_address[8*(ADDR_BYTES-1-r_addr_idx) +: 8];
        end else if (w_avail) begin
            w_head_byte = r_data[8*w_head_lane +: 8];
        end else begin
            w_head_byte = 8'h00;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_address_nxt    = r_address;
        w_addr_valid_nxt = r_addr_valid;
        w_addr_idx_nxt   = r_addr_idx;
        w_data_nxt       = r_data;
        w_lane_valid_nxt = r_lane_valid;
        w_overflow_nxt   = r_overflow;

        w_pop    = bus.i2c_read_data_i && w_avail;
        w_wr_req = bus.address_valid_i || (|bus.data_valid_i);
        w_wr_ok  = w_wr_req && (r_state == StIdle) && !w_pop;

        if (bus.clear_i) begin
            w_state_nxt      = StIdle;
            w_address_nxt    = '0;
            w_addr_valid_nxt = 1'b0;
            w_addr_idx_nxt   = '0;
            w_data_nxt       = '0;
            w_lane_valid_nxt = '0;
            w_overflow_nxt   = 1'b0;
        end else begin
            if (w_wr_req && !w_wr_ok) begin
                w_overflow_nxt = 1'b1;
            end
            if (w_wr_ok) begin
                if (bus.address_valid_i) begin
                    w_address_nxt    = bus.address_i;
                    w_addr_valid_nxt = 1'b1;
                    w_addr_idx_nxt   = '0;
                end
                for (int i = 0; i < DATA_BYTES; i++) begin
                    if (bus.data_valid_i[i]) begin
                        w_data_nxt[8*i +: 8] = bus.data_i[8*i +: 8];
                        w_lane_valid_nxt[i]  = 1'b1;
                    end
                end
            end
            if (w_pop) begin
                if (r_addr_valid) begin
                    if (w_last_addr) begin
                        w_addr_valid_nxt = 1'b0;
                        w_addr_idx_nxt   = '0;
                    end else begin
                        w_addr_idx_nxt = r_addr_idx + 1'b1;
                    end
                end else begin
                    w_lane_valid_nxt[w_head_lane] = 1'b0;
                end
                if (w_pending == PW'(1)) begin
                    w_state_nxt = StIdle;
                end else if (r_addr_valid && !w_last_addr) begin
                    w_state_nxt = StAddr;
                end else begin
                    w_state_nxt = StData;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= StIdle;
            r_address    <= '0;
            r_addr_valid <= 1'b0;
            r_addr_idx   <= '0;
            r_data       <= '0;
            r_lane_valid <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_address    <= w_address_nxt;
            r_addr_valid <= w_addr_valid_nxt;
            r_addr_idx   <= w_addr_idx_nxt;
            r_data       <= w_data_nxt;
            r_lane_valid <= w_lane_valid_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    assign bus.busy_o               = (r_state != StIdle);
    assign bus.i2c_data_available_o = w_avail;
    assign bus.i2c_data_o           = w_head_byte;
    assign bus.i2c_last_o           = (w_pending == PW'(1));
    assign bus.pending_o            = w_pending;
    assign bus.overflow_o           = r_overflow;
endmodule
